program_memory: RTL and testbench

PROGRAM_MEMORY -- requirements
Module: program_memory

---
 rtl/program_memory.sv | 135 +++++++++++++
 tb/tb_program_memory.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/program_memory.sv
// Program memory with a byte-stream boot loader.
// Holds DEPTH_WORDS 32-bit instruction words and serves registered fetches.
// A load_start request sends the block into a loader FSM. The loader packs
// incoming bytes little-endian into words and writes each one as it completes.
// While a load is in progress, the fetch port returns NOP_WORD.
module program_memory #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_bus_addr,
   output logic [31:0] instr_bus_data,
   input  logic        load_start,
   input  logic [15:0] load_words,
   input  logic [7:0]  load_byte,
   input  logic        load_valid,
   output logic        load_ready,
   output logic        load_busy,
   output logic        load_error
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      RUN,
      LOAD,
      COMMIT
   } state_t;

   state_t        state;
   logic [1:0]    byte_cnt;
   logic [AW-1:0] word_ptr;
   logic [AW-1:0] last_ptr;
   logic [23:0]   asm_word;

   logic [31:0]   mem [DEPTH_WORDS];

   logic [31:0]   words_ext;
   logic          words_in_range;
   logic          byte_xfer;
   logic          word_done;
   logic [AW-1:0] fetch_idx;
   logic          addr_oob;
   logic          unused_addr_bits;

   assign words_ext        = {16'd0, load_words};
   assign words_in_range   = (load_words != 16'd0) && (words_ext <= 32'(DEPTH_WORDS));
   assign byte_xfer        = (state == LOAD) && load_valid;
   assign word_done        = byte_xfer && (byte_cnt == 2'd3);
   assign fetch_idx        = instr_bus_addr[AW+1:2];
   assign addr_oob         = |instr_bus_addr[31:AW+2];
   assign unused_addr_bits = ^instr_bus_addr[1:0];

   // Loader FSM: accepts load requests, assembles bytes into words, and
   // drives the registered handshake and status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         byte_cnt   <= 2'd0;
         word_ptr   <= '0;
         last_ptr   <= '0;
         asm_word   <= 24'd0;
         load_ready <= 1'b0;
         load_busy  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (load_start) begin
                  if (words_in_range) begin
                     state      <= LOAD;
                     byte_cnt   <= 2'd0;
                     word_ptr   <= '0;
                     last_ptr   <= load_words[AW-1:0] - AW'(1);
                     load_error <= 1'b0;
                     load_ready <= 1'b1;
                     load_busy  <= 1'b1;
                  end else begin
                     load_error <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (byte_xfer) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0:    asm_word[7:0]   <= load_byte;
                     2'd1:    asm_word[15:8]  <= load_byte;
                     2'd2:    asm_word[23:16] <= load_byte;
                     default: asm_word        <= asm_word;
                  endcase
                  if (word_done) begin
                     word_ptr <= word_ptr + AW'(1);
                     if (word_ptr == last_ptr) begin
                        state      <= COMMIT;
                        load_ready <= 1'b0;
                     end
                  end
               end
            end
            COMMIT: begin
               state     <= RUN;
               byte_cnt  <= 2'd0;
               load_busy <= 1'b0;
            end
            default: begin
               state      <= RUN;
               load_ready <= 1'b0;
               load_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Loader write port: the fourth byte completes the word in the same edge.
   always_ff @(posedge clk) begin
      if (word_done) begin
         mem[word_ptr] <= {load_byte, asm_word};
      end
   end

   // Fetch read port: the output is registered and forced to NOP while a
   // load is in progress or when the address is beyond the array.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_bus_data <= NOP_WORD;
      end else if (load_busy || addr_oob) begin
         instr_bus_data <= NOP_WORD;
      end else begin
         instr_bus_data <= mem[fetch_idx];
      end
   end

endmodule

// File: tb/tb_program_memory.sv
// Scoreboard bench for program_memory. Each stimulus cycle pushes the
// expected post-edge outputs into a queue. A monitor pops and compares them
// one time unit after the following rising edge.
module tb_program_memory;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        reset;
   logic [31:0] instr_bus_addr;
   logic [31:0] instr_bus_data;
   logic        load_start;
   logic [15:0] load_words;
   logic [7:0]  load_byte;
   logic        load_valid;
   logic        load_ready;
   logic        load_busy;
   logic        load_error;

   typedef struct {
      string       name;
      bit          chk_data;
      logic [31:0] data;
      logic        busy;
      logic        err;
      logic        rdy;
   } exp_t;

   exp_t sb[$];
   bit   req;
   int   assert_cnt;
   int   fail_cnt;

   logic [7:0] a_bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
   logic [7:0] c_bytes [7] = '{8'hAA, 8'hFF, 8'hBB, 8'hEE, 8'hCC, 8'h99, 8'hDD};
   logic       c_valid [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [7:0] d_bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

   program_memory #(
      .DEPTH_WORDS(1024),
      .NOP_WORD(NOP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .instr_bus_addr(instr_bus_addr),
      .instr_bus_data(instr_bus_data),
      .load_start(load_start),
      .load_words(load_words),
      .load_byte(load_byte),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .load_busy(load_busy),
      .load_error(load_error)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
      assert_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      assert_cnt++;
      if (sb.size() == 0) begin
         fail_cnt++;
         $display("[TB] FAIL scoreboard_underflow: got empty queue, expected an entry");
         return;
      end
      e = sb.pop_front();
      if (e.chk_data) compare({e.name, ".data"}, instr_bus_data, e.data);
      compare({e.name, ".busy"},  {31'd0, load_busy},  {31'd0, e.busy});
      compare({e.name, ".error"}, {31'd0, load_error}, {31'd0, e.err});
      compare({e.name, ".ready"}, {31'd0, load_ready}, {31'd0, e.rdy});
   endtask

   task automatic applyStimulus(
      input logic        rst,
      input logic [31:0] addr,
      input logic        st,
      input logic [15:0] nw,
      input logic        v,
      input logic [7:0]  b,
      input string       nm,
      input bit          cd,
      input logic [31:0] ed,
      input logic        eb,
      input logic        ee,
      input logic        er
   );
      exp_t e;
      @(negedge clk);
      reset          = rst;
      instr_bus_addr = addr;
      load_start     = st;
      load_words     = nw;
      load_valid     = v;
      load_byte      = b;
      e.name     = nm;
      e.chk_data = cd;
      e.data     = ed;
      e.busy     = eb;
      e.err      = ee;
      e.rdy      = er;
      sb.push_back(e);
      req = 1'b1;
   endtask

   // Monitor: compare DUT outputs after each edge that closes a stimulus cycle.
   always @(posedge clk) begin
      if (req) begin
         #1;
         checkOutput();
      end
   end

   // Directed stimulus sequence.
   initial begin
      assert_cnt     = 0;
      fail_cnt       = 0;
      req            = 1'b0;
      reset          = 1'b0;
      instr_bus_addr = 32'd0;
      load_start     = 1'b0;
      load_words     = 16'd0;
      load_valid     = 1'b0;
      load_byte      = 8'd0;

      applyStimulus(0, 0, 0, 0, 0, 8'h00, "reset0", 1, NOP, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 8'h00, "reset1", 1, NOP, 0, 0, 0);

      applyStimulus(1, 0, 1, 16'd2, 0, 8'h00, "a_start", 0, 0, 1, 0, 1);
      for (int i = 0; i < 8; i++)
         applyStimulus(1, 0, 0, 0, 1, a_bytes[i], $sformatf("a_byte%0d", i), 1, NOP, 1, 0, (i < 7));
      applyStimulus(1, 0, 0, 0, 0, 8'h00, "a_commit", 1, NOP, 0, 0, 0);
      applyStimulus(1, 32'h0, 0, 0, 0, 8'h00, "a_fetch0", 1, 32'h00000013, 0, 0, 0);
      applyStimulus(1, 32'h4, 0, 0, 0, 8'h00, "a_fetch4", 1, 32'h00100093, 0, 0, 0);
      applyStimulus(1, 32'h6, 0, 0, 0, 8'h00, "a_fetch6", 1, 32'h00100093, 0, 0, 0);
      applyStimulus(1, 32'h0001_0000, 0, 0, 0, 8'h00, "a_oob_hi", 1, NOP, 0, 0, 0);
      applyStimulus(1, 32'h0000_1000, 0, 0, 0, 8'h00, "a_oob_edge", 1, NOP, 0, 0, 0);
      applyStimulus(1, 32'h3, 0, 0, 0, 8'h00, "a_fetch3", 1, 32'h00000013, 0, 0, 0);

      applyStimulus(1, 32'h4, 1, 16'd0, 0, 8'h00, "b_zero", 1, 32'h00100093, 0, 1, 0);
      applyStimulus(1, 32'h4, 1, 16'd1025, 0, 8'h00, "b_big", 1, 32'h00100093, 0, 1, 0);
      applyStimulus(1, 32'h0, 0, 0, 0, 8'h00, "b_sticky", 1, 32'h00000013, 0, 1, 0);

      applyStimulus(1, 32'h4, 1, 16'd1, 0, 8'h00, "c_start", 1, 32'h00100093, 1, 0, 1);
      for (int i = 0; i < 7; i++)
         applyStimulus(1, 0, (i == 3), 16'd0, c_valid[i], c_bytes[i], $sformatf("c_step%0d", i),
                       1, NOP, 1, 0, (i < 6));
      applyStimulus(1, 0, 0, 0, 1, 8'h55, "c_commit", 1, NOP, 0, 0, 0);
      applyStimulus(1, 32'h0, 0, 0, 1, 8'h66, "c_fetch0", 1, 32'hDDCCBBAA, 0, 0, 0);
      applyStimulus(1, 32'h4, 0, 0, 0, 8'h00, "c_fetch4", 1, 32'h00100093, 0, 0, 0);

      applyStimulus(1, 32'h0, 1, 16'd2, 0, 8'h00, "d_start", 1, 32'hDDCCBBAA, 1, 0, 1);
      for (int i = 0; i < 6; i++)
         applyStimulus(1, 0, 0, 0, 1, d_bytes[i], $sformatf("d_byte%0d", i), 1, NOP, 1, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 8'h00, "d_reset", 1, NOP, 0, 0, 0);
      applyStimulus(1, 32'h0, 0, 0, 0, 8'h00, "d_fetch0", 1, 32'h44332211, 0, 0, 0);
      applyStimulus(1, 32'h4, 0, 0, 0, 8'h00, "d_fetch4", 1, 32'h00100093, 0, 0, 0);

      @(negedge clk);
      req = 1'b0;
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      assert_cnt++;
      if (sb.size() != 0) begin
         fail_cnt++;
         $display("[TB] FAIL drain_timeout: got %0d pending entries, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
